// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : shared types/constants for mmio_uart_tx                   |
// | Macro MMIO_UART_PARITY_EN adds the PARITY state.  Rev 1.0            |
// +----------------------------------------------------------------------+
package uart_pkg;

  localparam logic [31:0] c_tx_addr_default   = 32'h0000_0100;
  localparam logic [31:0] c_ctrl_addr_default = 32'h0000_0104;

`ifdef MMIO_UART_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } uart_state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
  } uart_state_t;
`endif

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO, push accepted when full if popping    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wptr;
  logic [c_aw-1:0]  r_rptr;
  logic [c_aw:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (c_aw+1)'(DEPTH));
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);
  assign rdata     = r_mem[r_rptr];
  assign count     = r_count;

  // Storage carries no reset; only pointers and occupancy are cleared.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mmio_uart_tx : store-bus driven 8N1 UART transmitter with TX FIFO    |
// | Macro MMIO_UART_PARITY_EN inserts an even-parity bit.  Rev 1.0       |
// +----------------------------------------------------------------------+
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] TX_ADDR      = c_tx_addr_default,
  parameter logic [31:0] CTRL_ADDR    = c_ctrl_addr_default,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          MemWrite,
  input  logic [31:0]                   DataAdr,
  input  logic [31:0]                   WriteData,
  output logic                          tx,
  output logic                          busy,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam logic [15:0] c_baud_last = 16'(CLKS_PER_BIT - 1);

  uart_state_t r_state, w_state_nxt;
  logic [15:0] r_baud, w_baud_nxt;
  logic [2:0]  r_bit, w_bit_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic        r_tx, w_tx_nxt;
  logic        r_ovf;
  logic        w_pop, w_push_req, w_clr, w_drop, w_empty, w_full, w_baud_end;
  logic [7:0]  w_rdata;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  logic        w_unused_wdata;

  assign w_unused_wdata = ^WriteData[31:8];
  assign w_push_req     = MemWrite && (DataAdr == TX_ADDR);
  assign w_clr          = MemWrite && (DataAdr == CTRL_ADDR) && WriteData[0];
  assign w_drop         = w_push_req && w_full && !w_pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push_req),
    .pop   (w_pop),
    .wdata (WriteData[7:0]),
    .rdata (w_rdata),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

`ifdef MMIO_UART_PARITY_EN
  logic r_par;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     r_par <= 1'b0;
    else if (w_pop) r_par <= even_parity(w_rdata);
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      if (w_drop)     r_ovf <= 1'b1;
      else if (w_clr) r_ovf <= 1'b0;
    end
  end

  assign w_baud_end = (r_baud == c_baud_last);

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud + 16'd1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        w_baud_nxt = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_rdata;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end
      end
`ifdef MMIO_UART_PARITY_EN
      PARITY: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          // Chain straight into the next frame when data is waiting.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_rdata;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_baud_nxt  = '0;
        w_state_nxt = IDLE;
      end
    endcase

    // Line level is registered from the upcoming state so tx is glitch-free.
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shift_nxt[0];
`ifdef MMIO_UART_PARITY_EN
      PARITY:  w_tx_nxt = r_par;
`endif
      default: w_tx_nxt = 1'b1;
    endcase
  end

  assign tx         = r_tx;
  assign busy       = (r_state != IDLE) || !w_empty;
  assign fifo_full  = w_full;
  assign fifo_count = w_count;
  assign overflow   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mmio_uart_tx : directed self-checking bench for mmio_uart_tx      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mmio_uart_tx;

  localparam int          CPB  = 4;
  localparam logic [31:0] TXA  = 32'h0000_0100;
  localparam logic [31:0] CTLA = 32'h0000_0104;
`ifdef MMIO_UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        tx;
  logic        busy;
  logic        fifo_full;
  logic [3:0]  fifo_count;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .TX_ADDR      (TXA),
    .CTRL_ADDR    (CTLA),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .DataAdr    (DataAdr),
    .WriteData  (WriteData),
    .tx         (tx),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    MemWrite  = 1'b1;
    DataAdr   = addr;
    WriteData = data;
    tick();
    MemWrite  = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
  endtask

  // Symbol i of the frame is exp[i]; each symbol must hold for CPB cycles.
  task automatic send_frame(input string tag, input logic [31:0] data, input logic [10:0] exp);
    store(TXA, data);
    for (int i = 0; i < FB*CPB; i++) begin
      tick();
      check($sformatf("%s_tx%0d", tag, i), {31'd0, tx}, {31'd0, exp[i/CPB]});
    end
    check({tag, "_busy_last"}, {31'd0, busy}, 32'd1);
    tick();
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int peak, busy_cyc, lows;
    logic tx_f2, tx_f3, done;

    reset = 1'b0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
    repeat (3) tick();
    check("rst_tx_held", {31'd0, tx}, 32'd1);
    reset = 1'b1;
    tick();
    check("rst_tx",    {31'd0, tx},        32'd1);
    check("rst_busy",  {31'd0, busy},      32'd0);
    check("rst_count", {28'd0, fifo_count}, 32'd0);
    check("rst_ovf",   {31'd0, overflow},  32'd0);

    store(32'h0000_0108, 32'h0000_0077);
    check("other_addr_count", {28'd0, fifo_count}, 32'd0);
    check("other_addr_busy",  {31'd0, busy},       32'd0);

`ifdef MMIO_UART_PARITY_EN
    send_frame("a5", 32'hDEAD_BEA5, {1'b1, 1'b0, 8'hA5, 1'b0});
`else
    send_frame("a5", 32'hDEAD_BEA5, {1'b0, 1'b1, 8'hA5, 1'b0});
`endif

    // Three stores on consecutive edges; busy time is counted from the tx fall.
    peak = 0; busy_cyc = 0; tx_f2 = 1'b1; tx_f3 = 1'b1; done = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc < 3) begin
        MemWrite  = 1'b1;
        DataAdr   = TXA;
        WriteData = 32'(32'h41 + cyc);
      end else begin
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
      end
      tick();
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (cyc == FB*CPB + 1)   tx_f2 = tx;
      if (cyc == 2*FB*CPB + 1) tx_f3 = tx;
      if (cyc >= 1) begin
        if (busy) busy_cyc++;
        else begin
          done = 1'b1;
          break;
        end
      end
    end
    check("b2b_peak",     32'(peak),         32'd2);
    check("b2b_busy_cyc", 32'(busy_cyc),     32'(3*FB*CPB));
    check("b2b_f2_start", {31'd0, tx_f2},    32'd0);
    check("b2b_f3_start", {31'd0, tx_f3},    32'd0);
    check("b2b_done",     {31'd0, done},     32'd1);

    store(TXA, 32'h55);
    repeat (3) tick();
    for (int i = 0; i < 10; i++) begin
      store(TXA, 32'(32'h60 + i));
      if (i == 7) begin
        check("fill8_count", {28'd0, fifo_count}, 32'd8);
        check("fill8_full",  {31'd0, fifo_full},  32'd1);
        check("fill8_ovf",   {31'd0, overflow},   32'd0);
      end
    end
    check("fill10_count", {28'd0, fifo_count}, 32'd8);
    check("fill10_full",  {31'd0, fifo_full},  32'd1);
    check("fill10_ovf",   {31'd0, overflow},   32'd1);
    store(CTLA, 32'h0000_0000);
    check("clr0_ovf", {31'd0, overflow}, 32'd1);
    store(CTLA, 32'h0000_0001);
    check("clr1_ovf",   {31'd0, overflow},   32'd0);
    check("clr1_count", {28'd0, fifo_count}, 32'd8);
    wait_idle("drain", 1000);

`ifdef MMIO_UART_PARITY_EN
    send_frame("par07", 32'h07, {1'b1, 1'b1, 8'h07, 1'b0});
`endif

    // Second byte queued so a frame would follow if the FIFO survived reset.
    store(TXA, 32'h00);
    store(TXA, 32'h00);
    repeat (17) tick();
    check("mid_bit3_tx", {31'd0, tx}, 32'd0);
    reset = 1'b0;
    #1;
    check("mid_rst_tx",    {31'd0, tx},         32'd1);
    check("mid_rst_count", {28'd0, fifo_count}, 32'd0);
    check("mid_rst_busy",  {31'd0, busy},       32'd0);
    repeat (2) tick();
    reset = 1'b1;
    lows = 0;
    repeat (60) begin
      tick();
      if (!tx || busy) lows++;
    end
    check("post_rst_quiet", 32'(lows), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter that sits downstream of the single-cycle core top level.
- Consumes the store-side bus the top level produces: MemWrite, DataAdr and WriteData.
- Stores to the TX address are queued in a small FIFO and serialised as 8N1 frames on tx.
- Gives programs running on the core a visible output channel without changing the core.

Parameters:
- TX_ADDR, 32'h0000_0100, byte address whose stores enqueue WriteData[7:0].
- CTRL_ADDR, 32'h0000_0104, byte address whose stores with WriteData[0]=1 clear the overflow flag.
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 8, entries; must be a power of two, at least 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- MemWrite  input  1  store strobe from the core.
- DataAdr  input  32  store address.
- WriteData  input  32  store data; only bits [7:0] are used.
- tx  output  1  serial line; idle high.
- busy  output  1  high when the FSM is not IDLE or the FIFO is non-empty.
- fifo_full  output  1  count == FIFO_DEPTH.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  output  1  sticky flag; set when a push is dropped.

Behaviour:
- Reset (reset=0, asynchronous):
  - tx=1, busy=0, fifo_full=0, fifo_count=0, overflow=0.
  - FSM in IDLE; baud counter, bit index and FIFO pointers cleared.
  - Reset mid-frame aborts the frame immediately and tx returns to 1.
- Push:
  - Condition: MemWrite && DataAdr==TX_ADDR, sampled at the rising edge.
  - Accepted when count<FIFO_DEPTH, or when a pop occurs on the same edge.
  - Otherwise the data is dropped and overflow is set to 1 on that edge.
- Overflow clear: MemWrite && DataAdr==CTRL_ADDR && WriteData[0] clears overflow. If a clear and a drop occur on the same edge, set wins.
- Other addresses are ignored.
- Pop: occurs on the edge on which the FSM enters START; the popped byte is latched into the shift register.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then shift right. After bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
  - End of STOP: if the FIFO is non-empty, pop and go directly to START (back-to-back frames with no idle gap); otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and reloads to 0 on every state or bit change.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- Latency: a push on edge N into an empty FIFO with the FSM in IDLE gives a pop at edge N+1, and tx falls after edge N+1.
- tx is driven from a register (glitch-free).
- fifo_count reflects the state after the edge: +1 on push-only, -1 on pop-only, unchanged on push+pop.

Optional Feature:
- Macro: MMIO_UART_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. tx carries the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame length becomes 11*CLKS_PER_BIT.
- Undefined: no PARITY state exists and the frame is 8N1.

Decomposition:
- Package uart_pkg:
  - uart_state_t enum {IDLE, START, DATA, STOP, PARITY}; PARITY is present only under the macro.
  - Default TX_ADDR and CTRL_ADDR constants.
- Sub-module sync_fifo: parameters WIDTH=8 and DEPTH; ports push, pop, wdata, rdata, count, full, empty; same clk and reset.
- mmio_uart_tx contains the address decode, overflow flag, baud counter and FSM.

Test Plan:
- Hold reset=0 for 3 cycles, then release → tx=1, busy=0, fifo_count=0, overflow=0.
- CLKS_PER_BIT=4; store 32'hDEAD_BEA5 to 0x100 → tx sequence 0,1,0,1,0,0,1,0,1,1, each level for 4 cycles (start, LSB-first 0xA5, stop); busy returns to 0 one cycle after stop ends.
- Store 0x41, 0x42 and 0x43 on consecutive cycles → three frames back-to-back with no idle gap; fifo_count peaks at 2; total busy time is 120 cycles.
- Fill the FIFO with 10 stores while tx is active, with no pop coinciding → fifo_full=1; the excess pushes are dropped; overflow=1; then store 1 to 0x104 → overflow=0.
- Assert reset mid-way through DATA bit 3 → tx=1 immediately; fifo_count=0; no further frame after release.
- With MMIO_UART_PARITY_EN defined, send 0x07 → parity bit 1 precedes stop; frame lasts 11*CLKS_PER_BIT cycles.
